mvu_pe_seq_ctrl: RTL
====================

Name: mvu_pe_seq_ctrl

Overview:
Sequencer for one MVAU stream of PEs, each PE built from binary SIMD multipliers, an adder tree and an accumulator. It accepts the input activation stream with a valid/ready handshake. It generates do_mvau_stream, input-buffer write/read addressing for activation reuse across neuron folds, weight-memory addresses, and accumulator first/last strobes aligned to datapath latency. It also produces the output valid, holds it under backpressure, and freezes the pipeline while stalled.

Parameters:
SF, 4, synapse fold = MatrixW/SIMD; cycles per output vector; >=1
NF, 2, neuron fold = MatrixH/PE; output vectors per input vector; >=1
PIPE_LAT, 2, cycles from do_mvau_stream to accumulator update (SIMD reg + adder tree); >=1
WA, $clog2(SF*NF) (min 1), weight-memory address width
BA, $clog2(SF) (min 1), input-buffer address width

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
in_v  in  1  input activation word valid
in_rdy  out  1  controller accepts input word this cycle
out_rdy  in  1  downstream accepts output vector
do_mvau_stream  out  1  datapath advance strobe to SIMD units
pipe_en  out  1  enable for adder tree / accumulator / tap pipeline
act_sel  out  1  0: activation from stream, 1: from input buffer
ib_wr_en  out  1  input-buffer write enable
ib_addr  out  BA  input-buffer write/read address (= sf)
wmem_addr  out  WA  weight-memory read address
acc_first  out  1  accumulator clear-and-load strobe, delayed PIPE_LAT
acc_last  out  1  final accumulation of a vector, delayed PIPE_LAT
out_v  out  1  output vector valid

Behaviour:
- Reset: state FILL; sf, nf, wmem_addr = 0; tap pipeline cleared; all strobes and out_v = 0. Reset mid-operation discards the partial vector and any in-flight taps.
- States: FILL (nf==0, consume stream), REUSE (nf>0, replay buffer).
- stall = out_v & ~out_rdy. pipe_en = ~stall.
- in_rdy = (state==FILL) & ~stall. Handshake is in_v & in_rdy. in_v may assert with in_rdy low; the word must be held.
- do_mvau_stream = (FILL & in_v & in_rdy) | (REUSE & ~stall).
- ib_wr_en = do_mvau_stream & FILL. act_sel = (state==REUSE). ib_addr = sf.
- On do_mvau_stream:
  - sf increments, wrapping at SF-1.
  - On sf wrap, nf increments, wrapping at NF-1.
  - FILL->REUSE on the first sf wrap if NF>1.
  - REUSE->FILL on the nf wrap.
  - NF==1: never enters REUSE; buffer writes still issued but unused.
- wmem_addr: running counter, +1 per do_mvau_stream, wraps SF*NF-1 -> 0. Invariant: equals nf*SF+sf.
- Taps: first = do & sf==0; last = do & sf==SF-1. SF==1: both set the same cycle.
  - Delayed PIPE_LAT stages via a shift register advancing only when pipe_en.
  - acc_first/acc_last = stage outputs gated by pipe_en.
- out_v: set the cycle after acc_last emerges. Held until out_rdy (stall holds all state). Cleared on out_v & out_rdy unless a new acc_last emerges the same cycle, in which case it stays 1.
- A new vector's SF cycles overlap the previous output's wait. A stall freezes in_rdy, the counters and the taps together, so no data is lost.

Optional Feature:
MVAU_PERF_CNT_EN.
- Defined: adds ports stall_cnt (32b out) and vec_cnt (32b out).
  - stall_cnt counts cycles with stall=1.
  - vec_cnt counts out_v & out_rdy.
  - Both are saturating, zeroed by reset.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package mvau_ctrl_pkg: state enum {FILL, REUSE}; tap struct {first, last}; functions addr_w(n) returning max(1,$clog2(n)).
- Sub-module mvu_ctrl_tap_pipe: PIPE_LAT-deep enabled shift register of the tap struct with synchronous reset.
- Counters and FSM stay in the top.

Test Plan:
- SF=4,NF=2,PIPE_LAT=2, in_v=1, out_rdy=1:
  - in_rdy high 4 cycles, then low 4 (REUSE).
  - wmem_addr 0..7; ib_addr 0,1,2,3,0,1,2,3; act_sel 0x4 then 1x4.
  - acc_first 2 cycles after sf=0; out_v pulses twice.
- Same config, in_v toggling 1/0 in FILL: do_mvau_stream only on handshakes; sf never advances without in_v; wmem_addr stays consistent.
- out_rdy=0 when first out_v rises: stall=1; in_rdy, do_mvau_stream, pipe_en = 0; counters frozen. After out_rdy=1 resumes the exact next wmem_addr.
- SF=1,NF=1: acc_first = acc_last every cycle; out_v continuous at in_v rate; act_sel always 0.
- Reset asserted at sf=2,nf=1 (REUSE): next cycle FILL, wmem_addr=0, out_v=0, no stale acc_last emerges afterwards.
- MVAU_PERF_CNT_EN defined, 3-cycle stall then 2 vectors drained: stall_cnt=3, vec_cnt=2.

Source files
------------

// File: rtl/mvau_ctrl_pkg.sv
// Shared types for the MVAU stream sequencer: FSM state, accumulator tap
// strobes and an address-width helper.
package mvau_ctrl_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    REUSE = 1'b1
  } state_t;

  typedef struct packed {
    logic first;
    logic last;
  } tap_t;

  // Width of a counter indexing n entries; never narrower than one bit.
  function automatic int addr_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mvu_pe_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the MVAU sequencer (master)
// and the activation source / PE datapath / output sink (slave).
interface mvu_pe_seq_ctrl_if #(
  parameter int BA = 2,
  parameter int WA = 3
);
  logic          in_v;
  logic          in_rdy;
  logic          out_rdy;
  logic          do_mvau_stream;
  logic          pipe_en;
  logic          act_sel;
  logic          ib_wr_en;
  logic [BA-1:0] ib_addr;
  logic [WA-1:0] wmem_addr;
  logic          acc_first;
  logic          acc_last;
  logic          out_v;

  modport master (
    input  in_v, out_rdy,
    output in_rdy, do_mvau_stream, pipe_en, act_sel, ib_wr_en,
           ib_addr, wmem_addr, acc_first, acc_last, out_v
  );

  modport slave (
    output in_v, out_rdy,
    input  in_rdy, do_mvau_stream, pipe_en, act_sel, ib_wr_en,
           ib_addr, wmem_addr, acc_first, acc_last, out_v
  );
endinterface

// File: rtl/mvu_ctrl_tap_pipe.sv
// DEPTH-stage shift register carrying accumulator first/last taps in step with
// the datapath; advances only when en is high, cleared by synchronous reset.
module mvu_ctrl_tap_pipe
  import mvau_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  tap_t d,
  output tap_t q
);

  tap_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/mvu_pe_seq_ctrl.sv
// MVAU stream sequencer: fold counters, FILL/REUSE FSM, PIPE_LAT-aligned acc strobes,
// out_v held under backpressure (stall freezes everything). MVAU_PERF_CNT_EN adds perf counters.
module mvu_pe_seq_ctrl
  import mvau_ctrl_pkg::*;
#(
  parameter int SF       = 4,
  parameter int NF       = 2,
  parameter int PIPE_LAT = 2,
  parameter int WA       = addr_w(SF*NF),
  parameter int BA       = addr_w(SF)
) (
  input  logic              clk,
  input  logic              rst_n,
  mvu_pe_seq_ctrl_if.master bus
`ifdef MVAU_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       vec_cnt
`endif
);

  localparam int            NA     = addr_w(NF);
  localparam logic [BA-1:0] SF_MAX = BA'(SF - 1);
  localparam logic [NA-1:0] NF_MAX = NA'(NF - 1);
  localparam logic [WA-1:0] WM_MAX = WA'(SF * NF - 1);

  state_t        state;
  logic [BA-1:0] sf;
  logic [NA-1:0] nf;
  logic [WA-1:0] wmem_addr;
  logic          out_v;
  logic          stall;
  logic          advance;
  logic          sf_wrap;
  logic          nf_wrap;
  tap_t          tap_in;
  tap_t          tap_out;

  assign stall   = out_v & ~bus.out_rdy;
  assign advance = (state == FILL) ? (bus.in_v & ~stall) : ~stall;
  assign sf_wrap = (sf == SF_MAX);
  assign nf_wrap = (nf == NF_MAX);

  // wmem_addr runs as its own counter so it never needs a multiply; it tracks nf*SF+sf.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FILL;
      sf        <= '0;
      nf        <= '0;
      wmem_addr <= '0;
    end else if (advance) begin
      sf        <= sf_wrap ? '0 : sf + 1'b1;
      wmem_addr <= (wmem_addr == WM_MAX) ? '0 : wmem_addr + 1'b1;
      if (sf_wrap) begin
        nf <= nf_wrap ? '0 : nf + 1'b1;
        if (state == FILL) begin
          if (NF > 1) state <= REUSE;
        end else if (nf_wrap) begin
          state <= FILL;
        end
      end
    end
  end

  assign tap_in.first = advance & (sf == '0);
  assign tap_in.last  = advance & sf_wrap;

  mvu_ctrl_tap_pipe #(
    .DEPTH (PIPE_LAT)
  ) u_tap_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~stall),
    .d     (tap_in),
    .q     (tap_out)
  );

  // While stalled out_v is necessarily 1 and must hold; otherwise it follows the emerging last tap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_v <= 1'b0;
    end else if (!stall) begin
      out_v <= tap_out.last;
    end
  end

  assign bus.in_rdy         = (state == FILL) & ~stall;
  assign bus.do_mvau_stream = advance;
  assign bus.pipe_en        = ~stall;
  assign bus.act_sel        = (state == REUSE);
  assign bus.ib_wr_en       = advance & (state == FILL);
  assign bus.ib_addr        = sf;
  assign bus.wmem_addr      = wmem_addr;
  assign bus.acc_first      = tap_out.first & ~stall;
  assign bus.acc_last       = tap_out.last & ~stall;
  assign bus.out_v          = out_v;

`ifdef MVAU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      vec_cnt   <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (out_v && bus.out_rdy && (vec_cnt != '1)) vec_cnt <= vec_cnt + 32'd1;
    end
  end
`endif

endmodule
